// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types and helpers for the convolution scheduler.
//                - state_t : scheduler FSM state encoding (IDLE / RUN / DONE)
//                - addr_w  : index/address width for a given element count,
//                            never narrower than one bit
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_idx_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : conv_idx_cnt
//  Description : Six-level nested index counter for the loop nest
//                m(M_p) > r(R_p) > c(C_p) > n(N_p) > i(K_p) > j(K_p).
//                Exposes the index tuple one step ahead of the held one so
//                the parent can register operation fields without latency.
//  Ports       : clk_i, rst_n_i   clock / async active-low reset
//                clr_i            zero all indices
//                adv_i            step the nest by one position
//                *_nx_o           index tuple after one step
//                last_o           held tuple is the final position
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_idx_cnt
    import cnn_pkg::*;
#(
    parameter int N_p = 4,
    parameter int M_p = 4,
    parameter int K_p = 2,
    parameter int R_p = 16,
    parameter int C_p = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clr_i,
    input  logic                      adv_i,
    output logic [addr_w(M_p)-1:0]    m_nx_o,
    output logic [addr_w(R_p)-1:0]    r_nx_o,
    output logic [addr_w(C_p)-1:0]    c_nx_o,
    output logic [addr_w(N_p)-1:0]    n_nx_o,
    output logic [addr_w(K_p)-1:0]    i_nx_o,
    output logic [addr_w(K_p)-1:0]    j_nx_o,
    output logic                      last_o
);

    localparam int MW = addr_w(M_p);
    localparam int RW = addr_w(R_p);
    localparam int CW = addr_w(C_p);
    localparam int NW = addr_w(N_p);
    localparam int KW = addr_w(K_p);

    localparam logic [MW-1:0] C_M_MAX = MW'(M_p - 1);
    localparam logic [RW-1:0] C_R_MAX = RW'(R_p - 1);
    localparam logic [CW-1:0] C_C_MAX = CW'(C_p - 1);
    localparam logic [NW-1:0] C_N_MAX = NW'(N_p - 1);
    localparam logic [KW-1:0] C_K_MAX = KW'(K_p - 1);

    logic [MW-1:0] r_m;
    logic [RW-1:0] r_r;
    logic [CW-1:0] r_c;
    logic [NW-1:0] r_n;
    logic [KW-1:0] r_i;
    logic [KW-1:0] r_j;

    logic w_m_max, w_r_max, w_c_max, w_n_max, w_i_max, w_j_max;
    // w_*_cy: every level inside this one is at its maximum, so it steps
    logic w_i_cy, w_n_cy, w_c_cy, w_r_cy, w_m_cy;

    assign w_m_max = (r_m == C_M_MAX);
    assign w_r_max = (r_r == C_R_MAX);
    assign w_c_max = (r_c == C_C_MAX);
    assign w_n_max = (r_n == C_N_MAX);
    assign w_i_max = (r_i == C_K_MAX);
    assign w_j_max = (r_j == C_K_MAX);

    assign w_i_cy = w_j_max;
    assign w_n_cy = w_i_cy & w_i_max;
    assign w_c_cy = w_n_cy & w_n_max;
    assign w_r_cy = w_c_cy & w_c_max;
    assign w_m_cy = w_r_cy & w_r_max;

    assign j_nx_o = w_j_max ? '0 : r_j + 1'b1;
    assign i_nx_o = !w_i_cy ? r_i : (w_i_max ? '0 : r_i + 1'b1);
    assign n_nx_o = !w_n_cy ? r_n : (w_n_max ? '0 : r_n + 1'b1);
    assign c_nx_o = !w_c_cy ? r_c : (w_c_max ? '0 : r_c + 1'b1);
    assign r_nx_o = !w_r_cy ? r_r : (w_r_max ? '0 : r_r + 1'b1);
    assign m_nx_o = !w_m_cy ? r_m : (w_m_max ? '0 : r_m + 1'b1);

    assign last_o = w_m_cy & w_m_max;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_m <= '0;
            r_r <= '0;
            r_c <= '0;
            r_n <= '0;
            r_i <= '0;
            r_j <= '0;
        end else if (clr_i) begin
            r_m <= '0;
            r_r <= '0;
            r_c <= '0;
            r_n <= '0;
            r_i <= '0;
            r_j <= '0;
        end else if (adv_i) begin
            r_m <= m_nx_o;
            r_r <= r_nx_o;
            r_c <= c_nx_o;
            r_n <= n_nx_o;
            r_i <= i_nx_o;
            r_j <= j_nx_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sched
//  Description : Convolution address scheduler. Walks the loop nest
//                m > r > c > n > i > j (stride 1, bottom/right zero padding)
//                and offers one MAC operation per cycle over a valid/ready
//                handshake. All outputs are registered.
//  Ports       : clk_i, rst_n_i          clock / async active-low reset
//                start_i, abort_i        launch / cancel a pass
//                busy_o, done_o          pass status, one-cycle done pulse
//                op_valid_o, op_ready_i  operation handshake
//                in_addr_o, wt_addr_o,   operand / result addresses
//                out_addr_o
//                pad_o, first_o, last_o  operation qualifiers
//                cycles_o, stalls_o      RUN / stall cycle counters
//                                        (only with CONV_SCHED_PERF_EN)
//  Build macro : CONV_SCHED_PERF_EN - adds the performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_sched
    import cnn_pkg::*;
#(
    parameter int N_p = 4,
    parameter int M_p = 4,
    parameter int K_p = 2,
    parameter int R_p = 16,
    parameter int C_p = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  op_valid_o,
    input  logic                                  op_ready_i,
    output logic [addr_w(N_p*R_p*C_p)-1:0]        in_addr_o,
    output logic [addr_w(M_p*N_p*K_p*K_p)-1:0]    wt_addr_o,
    output logic [addr_w(M_p*R_p*C_p)-1:0]        out_addr_o,
    output logic                                  pad_o,
    output logic                                  first_o,
    output logic                                  last_o
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]                           cycles_o,
    output logic [31:0]                           stalls_o
`endif
);

    localparam int MW  = addr_w(M_p);
    localparam int RW  = addr_w(R_p);
    localparam int CW  = addr_w(C_p);
    localparam int NW  = addr_w(N_p);
    localparam int KW  = addr_w(K_p);
    localparam int INW = addr_w(N_p*R_p*C_p);
    localparam int WTW = addr_w(M_p*N_p*K_p*K_p);
    localparam int OUW = addr_w(M_p*R_p*C_p);

    state_t r_state;

    logic [MW-1:0] w_m_nx, w_sel_m;
    logic [RW-1:0] w_r_nx, w_sel_r;
    logic [CW-1:0] w_c_nx, w_sel_c;
    logic [NW-1:0] w_n_nx, w_sel_n;
    logic [KW-1:0] w_i_nx, w_sel_i;
    logic [KW-1:0] w_j_nx, w_sel_j;
    logic          w_cnt_last;

    logic w_start_acc;
    logic w_xfer;
    logic w_load;

    int             w_ri;
    int             w_cj;
    logic           w_pad;
    logic           w_first;
    logic           w_last;
    logic [INW-1:0] w_in_addr;
    logic [WTW-1:0] w_wt_addr;
    logic [OUW-1:0] w_out_addr;

    assign w_start_acc = (r_state == ST_IDLE) & start_i & ~abort_i;
    assign w_xfer      = (r_state == ST_RUN) & op_valid_o & op_ready_i & ~abort_i;
    // Payload is refreshed on a start and on every transfer except the final
    // one, so it always describes the operation currently being offered.
    assign w_load      = w_start_acc | (w_xfer & ~w_cnt_last);

    conv_idx_cnt #(
        .N_p (N_p),
        .M_p (M_p),
        .K_p (K_p),
        .R_p (R_p),
        .C_p (C_p)
    ) u_idx (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (w_start_acc),
        .adv_i   (w_xfer),
        .m_nx_o  (w_m_nx),
        .r_nx_o  (w_r_nx),
        .c_nx_o  (w_c_nx),
        .n_nx_o  (w_n_nx),
        .i_nx_o  (w_i_nx),
        .j_nx_o  (w_j_nx),
        .last_o  (w_cnt_last)
    );

    // From IDLE the first operation is the all-zero tuple; otherwise the
    // counter's look-ahead tuple is the operation offered after this edge.
    assign w_sel_m = (r_state == ST_IDLE) ? '0 : w_m_nx;
    assign w_sel_r = (r_state == ST_IDLE) ? '0 : w_r_nx;
    assign w_sel_c = (r_state == ST_IDLE) ? '0 : w_c_nx;
    assign w_sel_n = (r_state == ST_IDLE) ? '0 : w_n_nx;
    assign w_sel_i = (r_state == ST_IDLE) ? '0 : w_i_nx;
    assign w_sel_j = (r_state == ST_IDLE) ? '0 : w_j_nx;

    always_comb begin
        w_ri       = int'(w_sel_r) + int'(w_sel_i);
        w_cj       = int'(w_sel_c) + int'(w_sel_j);
        w_pad      = (w_ri >= R_p) || (w_cj >= C_p);
        w_in_addr  = w_pad ? '0 :
                     INW'(int'(w_sel_n) * R_p * C_p + w_ri * C_p + w_cj);
        w_wt_addr  = WTW'(int'(w_sel_m) * N_p * K_p * K_p +
                          int'(w_sel_n) * K_p * K_p +
                          int'(w_sel_i) * K_p + int'(w_sel_j));
        w_out_addr = OUW'(int'(w_sel_m) * R_p * C_p +
                          int'(w_sel_r) * C_p + int'(w_sel_c));
        w_first    = (w_sel_n == '0) && (w_sel_i == '0) && (w_sel_j == '0);
        w_last     = (int'(w_sel_n) == N_p - 1) &&
                     (int'(w_sel_i) == K_p - 1) &&
                     (int'(w_sel_j) == K_p - 1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            op_valid_o <= 1'b0;
            in_addr_o  <= '0;
            wt_addr_o  <= '0;
            out_addr_o <= '0;
            pad_o      <= 1'b0;
            first_o    <= 1'b0;
            last_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        r_state    <= ST_RUN;
                        busy_o     <= 1'b1;
                        op_valid_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        r_state    <= ST_IDLE;
                        busy_o     <= 1'b0;
                        op_valid_o <= 1'b0;
                    end else if (op_valid_o && op_ready_i && w_cnt_last) begin
                        r_state    <= ST_DONE;
                        op_valid_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= !abort_i;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    busy_o     <= 1'b0;
                    op_valid_o <= 1'b0;
                end
            endcase

            if (w_load) begin
                in_addr_o  <= w_in_addr;
                wt_addr_o  <= w_wt_addr;
                out_addr_o <= w_out_addr;
                pad_o      <= w_pad;
                first_o    <= w_first;
                last_o     <= w_last;
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycles_o <= '0;
            stalls_o <= '0;
        end else if (w_start_acc) begin
            cycles_o <= '0;
            stalls_o <= '0;
        end else if (r_state == ST_RUN) begin
            cycles_o <= cycles_o + 32'd1;
            if (op_valid_o && !op_ready_i) begin
                stalls_o <= stalls_o + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
